alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered ALU with valid/ready handshake on both sides. Successor to the fixed 32-bit ALU.
//  Adds generic WIDTH, status flags, flow control and an optional iterative multiplier.
//  Sits between an operand-issue stage and a result consumer. One operation in flight at a time.
//  Throughput is one op/cycle for single-cycle ops.
// PARAMETERS
//  WIDTH    32   operand/result width in bits; legal range >= 8, power of two
//  SHW      $clog2(WIDTH)   shift-amount width (derived localparam; not overridable)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand/opcode valid
//  in_ready   out  1      block can accept an op this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (shift ops use b[SHW-1:0])
//  sel        in   4      opcode, see BEHAVIOUR
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts result this cycle
//  result     out  WIDTH  registered result
//  flags      out  5      {err, ovf, carry, neg, zero}, registered with result
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, result=0, flags=0, FSM=IDLE, mul counter=0.
//  While rst_n=0, in_ready=0. Reset mid-multiply aborts the op; nothing is emitted.
//  in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  Held output: while out_valid && !out_ready, result/flags/out_valid are held stable.
//  out_valid clears on (out_valid && out_ready) unless a new op completes in the same cycle.
//  Opcodes: 0000 ADD; 0001 SUB (a-b); 0010 AND; 0011 OR; 0100 XOR; 0101 NOR.
//  Opcodes (cont.): 0110 SLT (signed, result 0/1); 0111 SLTU; 1000 SLL; 1001 SRL; 1010 SRA; 1011 PASSB.
//  Opcodes (cont.): 1100 MUL (macro-dependent); 1101-1111 illegal.
//  Single-cycle ops: accepted in cycle N -> out_valid=1 with result in cycle N+1 (latency 1).
//  Back-to-back accepts are allowed when out_ready=1.
//  Arithmetic is modulo 2^WIDTH. SUB computes a + ~b + 1.
//  zero=(result==0). neg=result[WIDTH-1].
//  carry = carry-out of the WIDTH-bit adder for ADD/SUB (SUB: 1 = no borrow); 0 for all other ops.
//  ovf = signed overflow for ADD/SUB only; 0 otherwise.
//  Shifts use b[SHW-1:0] only; upper b bits are ignored. SRA replicates a[WIDTH-1].
//  Illegal opcode: result=0, err=1, other flags computed from result=0 (zero=1). Latency 1.
//  FSM: IDLE --accept MUL--> BUSY (counter=WIDTH-1) --counter==0--> IDLE, asserting out_valid.
//  Accepting MUL requires the prior result to be consumed that cycle, so out_valid=0 throughout BUSY.
// CONFIGURATION
//  ALU_PIPE_MUL_EN defined:
//   - MUL = low WIDTH bits of unsigned a*b, computed by a shift-add, one bit/cycle.
//   - Accept in cycle N -> out_valid in cycle N+WIDTH; in_ready=0 while BUSY.
//   - MUL flags: zero/neg from result; carry=0; err=0; ovf=1 iff high WIDTH product bits != 0.
//  ALU_PIPE_MUL_EN undefined:
//   - no BUSY state or multiplier logic is built; in_ready=(!out_valid || out_ready).
//   - 1100 is treated as illegal (result=0, err=1, latency 1).
// TESTING (WIDTH=32 unless noted)
//  1. Reset mid-op: rst_n=0 during BUSY, or with out_valid held -> out_valid=0, result=0, in_ready=1 after release.
//  2. Add/sub flags:
//     - ADD a=32'hFFFF_FFFF b=1 -> result=0, zero=1, carry=1, ovf=0.
//     - ADD a=32'h7FFF_FFFF b=1 -> result 8000_0000, neg=1, ovf=1.
//  3. SUB/compare:
//     - SUB a=0 b=1 -> result FFFF_FFFF, carry=0, neg=1.
//     - SLT a=FFFF_FFFF b=1 -> 1.
//     - SLTU same operands -> 0.
//  4. Shifts: SRA a=8000_0000 b=32'h0000_0104 (amount 4) -> F800_0000. SLL a=1 b=31 -> 8000_0000.
//  5. Backpressure: 3 back-to-back ADDs with out_ready=0 for 4 cycles:
//     - first result held stable, in_ready=0.
//     - after out_ready=1, results drain in order, one per cycle, none lost or duplicated.
//  6. Multiply:
//     - with ALU_PIPE_MUL_EN: MUL a=32'h0001_0001 b=32'h0001_0001 -> result 0002_0001, ovf=1, out_valid exactly 32 cycles after accept.
//     - without ALU_PIPE_MUL_EN: same op -> result 0, err=1, one cycle after accept.
//     - any: sel=4'b1111 -> err=1, zero=1.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready flow control and status flags.
// Optional shift-add multiplier built only when ALU_PIPE_MUL_EN is defined.
module alu_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       flags
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLTU = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_PASB = 4'd11;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [4:0]       flags_q, flags_d;
   logic             accept;

   logic [WIDTH-1:0] b_op, alu_res;
   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   shamt;
   logic             is_sub, alu_carry, alu_ovf, alu_err;

   always_comb begin
      is_sub    = (sel == OP_SUB);
      b_op      = is_sub ? ~b : b;
      sum       = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
      shamt     = b[SHW-1:0];
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      alu_err   = 1'b0;
      unique case (sel)
         OP_ADD, OP_SUB: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ovf   = (a[WIDTH-1] == b_op[WIDTH-1]) &&
                        (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
         OP_PASB: alu_res = b;
         default: alu_err = 1'b1;
      endcase
   end

`ifdef ALU_PIPE_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd12;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic               is_mul;

   assign in_ready = rst_n && (state_q == IDLE) &&
                     (!out_valid_q || out_ready);
`else
   assign in_ready = rst_n && (!out_valid_q || out_ready);
`endif

   assign accept = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
`ifdef ALU_PIPE_MUL_EN
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      is_mul   = (sel == OP_MUL);
      // bit 0 is folded in at accept so the result lands WIDTH cycles later
      if (accept && is_mul) begin
         state_d  = BUSY;
         acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
         mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
         mplier_d = {1'b0, b[WIDTH-1:1]};
         cnt_d    = SHW'(WIDTH-1);
      end else if (accept) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         flags_d     = {alu_err, alu_ovf, alu_carry,
                        alu_res[WIDTH-1], ~|alu_res};
      end
      if (state_q == BUSY) begin
         acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - SHW'(1);
         if (cnt_q == SHW'(1)) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            result_d    = acc_d[WIDTH-1:0];
            flags_d     = {1'b0, |acc_d[2*WIDTH-1:WIDTH], 1'b0,
                           acc_d[WIDTH-1], ~|acc_d[WIDTH-1:0]};
         end
      end
`else
      if (accept) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         flags_d     = {alu_err, alu_ovf, alu_carry,
                        alu_res[WIDTH-1], ~|alu_res};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
`ifdef ALU_PIPE_MUL_EN
         state_q     <= IDLE;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
`ifdef ALU_PIPE_MUL_EN
         state_q     <= state_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
endmodule
